// File: rtl/debounced_switchbank.sv
// N-channel panel switch bank: two-flop sync, counter debounce, toggle/momentary.
// Optional SWITCHBANK_PRESS_EN adds the per-channel press pulse output.
module debounced_switchbank #(
    parameter int          N               = 8,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          CNT_BITS        = $clog2(DEBOUNCE_CYCLES),
    parameter logic [N-1:0] TOGGLE_MASK    = {N{1'b1}},
    parameter logic [N-1:0] RESET_VALUE    = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] buttons,
    input  logic         load,
    input  logic [N-1:0] load_value,
    output logic [N-1:0] switches,
    output logic         changed
`ifdef SWITCHBANK_PRESS_EN
    ,
    output logic [N-1:0] press
`endif
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [N-1:0] SW_RESET = RESET_VALUE & TOGGLE_MASK;

    logic [N-1:0]        sync1;
    logic [N-1:0]        sync2;
    logic [N-1:0]        stable;
    logic [CNT_BITS-1:0] cnt [N];

    logic [N-1:0] accept;
    logic [N-1:0] rise;
    logic [N-1:0] sw_next;

    always_comb begin
        accept  = '0;
        rise    = '0;
        sw_next = switches;
        for (int i = 0; i < N; i++) begin
            accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
            rise[i]   = accept[i] && sync2[i];
            if (TOGGLE_MASK[i]) begin
                // load overrides a same-edge toggle
                if (load)
                    sw_next[i] = load_value[i];
                else if (rise[i])
                    sw_next[i] = ~switches[i];
            end else if (accept[i]) begin
                sw_next[i] = sync2[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            switches <= SW_RESET;
            changed  <= 1'b0;
            for (int i = 0; i < N; i++)
                cnt[i] <= '0;
        end else begin
            sync1    <= buttons;
            sync2    <= sync1;
            switches <= sw_next;
            changed  <= (sw_next != switches);
            for (int i = 0; i < N; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_BITS'(1);
                end
            end
        end
    end

`ifdef SWITCHBANK_PRESS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            press <= '0;
        else
            press <= rise;
    end
`endif

endmodule
